// File: rtl/scene_packet_dispatcher_if.sv
// Bundle between the scene packet dispatcher, the SPI receive FIFO read port,
// the scene-memory write ports and the ray-tracing core status signals.
interface scene_packet_dispatcher_if #(
  parameter int DATA_W     = 32,
  parameter int VTX_ADDR_W = 10,
  parameter int TRI_ADDR_W = 10,
  parameter int CFG_DEPTH  = 16
);
  localparam int CFG_AW = $clog2(CFG_DEPTH);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_W-1:0]     fifo_dout;
  logic                  vtx_we;
  logic                  vtx_rdy;
  logic [VTX_ADDR_W-1:0] vtx_addr;
  logic                  tri_we;
  logic                  tri_rdy;
  logic [TRI_ADDR_W-1:0] tri_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  cfg_we;
  logic [CFG_AW-1:0]     cfg_addr;
  logic                  scene_clr;
  logic                  frame_done;
  logic [VTX_ADDR_W:0]   vtx_count;
  logic [TRI_ADDR_W:0]   tri_count;
  logic                  err_overflow;
  logic                  err_format;
  logic                  busy;

  modport master (
    input  fifo_empty, fifo_dout, vtx_rdy, tri_rdy, scene_clr,
    output fifo_rd_en, vtx_we, vtx_addr, tri_we, tri_addr, mem_wdata,
           cfg_we, cfg_addr, frame_done, vtx_count, tri_count,
           err_overflow, err_format, busy
  );

  modport slave (
    output fifo_empty, fifo_dout, vtx_rdy, tri_rdy, scene_clr,
    input  fifo_rd_en, vtx_we, vtx_addr, tri_we, tri_addr, mem_wdata,
           cfg_we, cfg_addr, frame_done, vtx_count, tri_count,
           err_overflow, err_format, busy
  );
endinterface

// File: rtl/scene_packet_dispatcher.sv
// Drains the SPI receive FIFO, parses packet headers and steers payload words
// into vertex memory, triangle memory or the config register file.
module scene_packet_dispatcher #(
  parameter int DATA_W     = 32,
  parameter int VTX_ADDR_W = 10,
  parameter int TRI_ADDR_W = 10,
  parameter int CFG_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  scene_packet_dispatcher_if.master bus
);
  localparam int CFG_AW = $clog2(CFG_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR_CAP = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_PAY_REQ = 3'd3;
  localparam logic [2:0] S_PAY_CAP = 3'd4;
  localparam logic [2:0] S_PAY_WR  = 3'd5;
  localparam logic [2:0] S_FLUSH   = 3'd6;

  localparam logic [1:0] T_CFG = 2'b00;
  localparam logic [1:0] T_VTX = 2'b01;
  localparam logic [1:0] T_TRI = 2'b10;
  localparam logic [1:0] T_EOF = 2'b11;

  localparam logic [8:0]            CFG_LIMIT = 9'(CFG_DEPTH);
  localparam logic [VTX_ADDR_W:0]   VTX_ONE   = 1;
  localparam logic [TRI_ADDR_W:0]   TRI_ONE   = 1;
  localparam logic [CFG_AW-1:0]     CFG_ONE   = 1;

  logic [2:0]            r_state;
  logic [1:0]            r_type;
  logic [7:0]            r_len;
  logic [7:0]            r_remain;
  logic [CFG_AW-1:0]     r_cfg_idx;
  logic [VTX_ADDR_W:0]   r_vtx_ptr;
  logic [TRI_ADDR_W:0]   r_tri_ptr;
  logic [VTX_ADDR_W:0]   r_vtx_count;
  logic [TRI_ADDR_W:0]   r_tri_count;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_err_ovf;
  logic                  r_err_fmt;
  logic                  r_pend_clr;
  logic                  r_frame_done;
  logic                  r_flush_phase;

  logic w_vtx_full;
  logic w_tri_full;
  logic w_in_wr;
  logic w_vtx_we;
  logic w_tri_we;
  logic w_cfg_we;
  logic w_word_done;
  logic w_cfg_bad;
  logic w_hdr_rd;
  logic w_pay_rd;
  logic w_flush_rd;

  // A pointer with its top bit set has reached 2^ADDR_W: memory full, never wraps.
  assign w_vtx_full = r_vtx_ptr[VTX_ADDR_W];
  assign w_tri_full = r_tri_ptr[TRI_ADDR_W];
  assign w_in_wr    = (r_state == S_PAY_WR);
  assign w_vtx_we   = w_in_wr && (r_type == T_VTX) && !w_vtx_full;
  assign w_tri_we   = w_in_wr && (r_type == T_TRI) && !w_tri_full;
  assign w_cfg_we   = w_in_wr && (r_type == T_CFG);
  assign w_cfg_bad  = (r_type == T_CFG) && ({1'b0, r_len} > CFG_LIMIT);

  assign w_hdr_rd   = (r_state == S_IDLE) && !r_pend_clr && !bus.fifo_empty;
  assign w_pay_rd   = (r_state == S_PAY_REQ) && !bus.fifo_empty;
  assign w_flush_rd = (r_state == S_FLUSH) && (r_remain != 8'd0) && !r_flush_phase
                      && !bus.fifo_empty;

  always_comb begin
    // NOTE: default first so no path through the case leaves the signal held (latch).
    w_word_done = 1'b0;
    if (w_in_wr) begin
      case (r_type)
        T_VTX:   w_word_done = w_vtx_full || bus.vtx_rdy;
        T_TRI:   w_word_done = w_tri_full || bus.tri_rdy;
        default: w_word_done = 1'b1;
      endcase
    end
  end

  assign bus.fifo_rd_en   = w_hdr_rd || w_pay_rd || w_flush_rd;
  assign bus.vtx_we       = w_vtx_we;
  assign bus.vtx_addr     = r_vtx_ptr[VTX_ADDR_W-1:0];
  assign bus.tri_we       = w_tri_we;
  assign bus.tri_addr     = r_tri_ptr[TRI_ADDR_W-1:0];
  assign bus.cfg_we       = w_cfg_we;
  assign bus.cfg_addr     = r_cfg_idx;
  assign bus.mem_wdata    = r_wdata;
  assign bus.frame_done   = r_frame_done;
  assign bus.vtx_count    = r_vtx_count;
  assign bus.tri_count    = r_tri_count;
  assign bus.err_overflow = r_err_ovf;
  assign bus.err_format   = r_err_fmt;
  assign bus.busy         = (r_state != S_IDLE);

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_type        <= T_CFG;
      r_len         <= '0;
      r_remain      <= '0;
      r_cfg_idx     <= '0;
      r_vtx_ptr     <= '0;
      r_tri_ptr     <= '0;
      r_vtx_count   <= '0;
      r_tri_count   <= '0;
      r_wdata       <= '0;
      r_err_ovf     <= 1'b0;
      r_err_fmt     <= 1'b0;
      r_pend_clr    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_flush_phase <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_pend_clr   <= r_pend_clr | bus.scene_clr;

      case (r_state)
        S_IDLE: begin
          if (r_pend_clr) begin
            r_vtx_ptr  <= '0;
            r_tri_ptr  <= '0;
            r_err_ovf  <= 1'b0;
            r_err_fmt  <= 1'b0;
            r_pend_clr <= bus.scene_clr;
          end else if (!bus.fifo_empty) begin
            r_state <= S_HDR_CAP;
          end
        end

        S_HDR_CAP: begin
          r_type  <= bus.fifo_dout[DATA_W-1:DATA_W-2];
          r_len   <= bus.fifo_dout[7:0];
          r_state <= S_DECODE;
        end

        S_DECODE: begin
          r_remain      <= r_len;
          r_cfg_idx     <= '0;
          r_flush_phase <= 1'b0;
          if (r_type == T_EOF && r_len == 8'd0) begin
            // Pulse is registered so it lines up with the freshly latched counts.
            r_vtx_count  <= r_vtx_ptr;
            r_tri_count  <= r_tri_ptr;
            r_vtx_ptr    <= '0;
            r_tri_ptr    <= '0;
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else if (r_type == T_EOF || w_cfg_bad) begin
            r_err_fmt <= 1'b1;
            r_state   <= S_FLUSH;
          end else if (r_len == 8'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_PAY_REQ;
          end
        end

        S_PAY_REQ: begin
          if (!bus.fifo_empty) r_state <= S_PAY_CAP;
        end

        S_PAY_CAP: begin
          r_wdata <= bus.fifo_dout;
          r_state <= S_PAY_WR;
        end

        S_PAY_WR: begin
          if ((r_type == T_VTX && w_vtx_full) || (r_type == T_TRI && w_tri_full))
            r_err_ovf <= 1'b1;
          if (w_vtx_we && bus.vtx_rdy) r_vtx_ptr <= r_vtx_ptr + VTX_ONE;
          if (w_tri_we && bus.tri_rdy) r_tri_ptr <= r_tri_ptr + TRI_ONE;
          if (w_cfg_we) r_cfg_idx <= r_cfg_idx + CFG_ONE;
          if (w_word_done) begin
            r_remain <= r_remain - 8'd1;
            r_state  <= (r_remain == 8'd1) ? S_IDLE : S_PAY_REQ;
          end
        end

        S_FLUSH: begin
          if (r_remain == 8'd0) begin
            r_state <= S_IDLE;
          end else if (r_flush_phase) begin
            r_flush_phase <= 1'b0;
            r_remain      <= r_remain - 8'd1;
            if (r_remain == 8'd1) r_state <= S_IDLE;
          end else if (!bus.fifo_empty) begin
            r_flush_phase <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scene_packet_dispatcher.sv
// Randomized bench for scene_packet_dispatcher: a packet-level model predicts
// every memory/config write, frame report, error flag and FIFO read count.
`timescale 1ns/1ps
module tb_scene_packet_dispatcher;
  localparam int DATA_W    = 32;
  localparam int VTX_AW    = 3;
  localparam int TRI_AW    = 3;
  localparam int CFG_DEPTH = 16;
  localparam int VDEPTH    = 1 << VTX_AW;
  localparam int TDEPTH    = 1 << TRI_AW;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { int vc; int tc; } frm_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scene_packet_dispatcher_if #(
    .DATA_W(DATA_W), .VTX_ADDR_W(VTX_AW), .TRI_ADDR_W(TRI_AW), .CFG_DEPTH(CFG_DEPTH)
  ) bus ();

  scene_packet_dispatcher #(
    .DATA_W(DATA_W), .VTX_ADDR_W(VTX_AW), .TRI_ADDR_W(TRI_AW), .CFG_DEPTH(CFG_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [31:0] fifo_q[$];
  wr_t  exp_vtx[$], exp_tri[$], exp_cfg[$];
  frm_t exp_frm[$];
  int   m_vptr, m_tptr, exp_reads, n_reads, cyc;
  bit   m_ovf, m_fmt;
  bit   rnd_rdy, rnd_stall;
  int   n_vec, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packet-level reference: what each header/payload must do to the scene.
  task automatic send_pkt(input logic [1:0] ty, input int len);
    logic [31:0] w;
    bit drop;
    drop = (ty == 2'b11 && len != 0) || (ty == 2'b00 && len > CFG_DEPTH);
    fifo_q.push_back({ty, 22'($urandom), 8'(len)});
    exp_reads += 1 + len;
    if (ty == 2'b11 && len == 0) begin
      exp_frm.push_back('{m_vptr, m_tptr});
      m_vptr = 0;
      m_tptr = 0;
    end
    if (drop) m_fmt = 1'b1;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      if (!drop) begin
        if (ty == 2'b00) exp_cfg.push_back('{i, w});
        else if (ty == 2'b01) begin
          if (m_vptr < VDEPTH) begin exp_vtx.push_back('{m_vptr, w}); m_vptr++; end
          else m_ovf = 1'b1;
        end else if (ty == 2'b10) begin
          if (m_tptr < TDEPTH) begin exp_tri.push_back('{m_tptr, w}); m_tptr++; end
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic m_clear();
    m_vptr = 0; m_tptr = 0; m_ovf = 1'b0; m_fmt = 1'b0;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return bus.fifo_rd_en;
      1:       return bus.vtx_we;
      2:       return bus.tri_we;
      default: return !bus.busy;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel);
    int n = 0;
    while (!cond(sel) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check({tag, "_timeout"}, 64'(cond(sel)), 64'd1);
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || bus.busy) && n < 20000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    if (n >= 20000) check({tag, "_timeout"}, 64'(fifo_q.size()) + 64'(bus.busy), 64'd0);
    check({tag, "_err_overflow"}, 64'(bus.err_overflow), 64'(m_ovf));
    check({tag, "_err_format"},   64'(bus.err_format),   64'(m_fmt));
    check({tag, "_fifo_reads"},   64'(n_reads),          64'(exp_reads));
    check({tag, "_missing_events"},
          64'(exp_vtx.size() + exp_tri.size() + exp_cfg.size() + exp_frm.size()), 64'd0);
  endtask

  // FIFO model: non-FWFT, data appears the cycle after the read strobe.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.fifo_rd_en) begin
      n_reads++;
      if (fifo_q.size() > 0) bus.fifo_dout <= fifo_q.pop_front();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.fifo_empty = (fifo_q.size() == 0) || (rnd_stall && $urandom_range(0, 3) == 0);
      if (rnd_rdy) begin
        bus.vtx_rdy = ($urandom_range(0, 2) != 0);
        bus.tri_rdy = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Monitor: every write, frame report and stall cycle is checked here.
  bit p_vst, p_tst;
  logic [63:0] p_vsig, p_tsig;
  always @(negedge clk) begin : mon
    wr_t e;
    frm_t f;
    if (rst_n) begin
      if (bus.vtx_we || bus.tri_we || bus.cfg_we)
        check("we_onehot", 64'($countones({bus.vtx_we, bus.tri_we, bus.cfg_we})), 64'd1);
      if (bus.fifo_rd_en) check("rd_on_empty", 64'(bus.fifo_empty), 64'd0);
      if (p_vst) begin
        check("vtx_hold", {31'd0, bus.vtx_we, 32'(bus.vtx_addr)} ^ {32'd0, bus.mem_wdata}, p_vsig);
        check("vtx_stall_rd", 64'(bus.fifo_rd_en), 64'd0);
      end
      if (p_tst) begin
        check("tri_hold", {31'd0, bus.tri_we, 32'(bus.tri_addr)} ^ {32'd0, bus.mem_wdata}, p_tsig);
        check("tri_stall_rd", 64'(bus.fifo_rd_en), 64'd0);
      end
      p_vst  = bus.vtx_we && !bus.vtx_rdy;
      p_tst  = bus.tri_we && !bus.tri_rdy;
      p_vsig = {31'd0, 1'b1, 32'(bus.vtx_addr)} ^ {32'd0, bus.mem_wdata};
      p_tsig = {31'd0, 1'b1, 32'(bus.tri_addr)} ^ {32'd0, bus.mem_wdata};
      if (bus.vtx_we && bus.vtx_rdy) begin
        if (exp_vtx.size() == 0) check("vtx_unexpected_wr", 64'(exp_vtx.size()), 64'd1);
        else begin
          e = exp_vtx.pop_front();
          check("vtx_wr", {32'(bus.vtx_addr), bus.mem_wdata}, {32'(e.addr), e.data});
        end
      end
      if (bus.tri_we && bus.tri_rdy) begin
        if (exp_tri.size() == 0) check("tri_unexpected_wr", 64'(exp_tri.size()), 64'd1);
        else begin
          e = exp_tri.pop_front();
          check("tri_wr", {32'(bus.tri_addr), bus.mem_wdata}, {32'(e.addr), e.data});
        end
      end
      if (bus.cfg_we) begin
        if (exp_cfg.size() == 0) check("cfg_unexpected_wr", 64'(exp_cfg.size()), 64'd1);
        else begin
          e = exp_cfg.pop_front();
          check("cfg_wr", {32'(bus.cfg_addr), bus.mem_wdata}, {32'(e.addr), e.data});
        end
      end
      if (bus.frame_done) begin
        if (exp_frm.size() == 0) check("frame_unexpected", 64'(exp_frm.size()), 64'd1);
        else begin
          f = exp_frm.pop_front();
          check("frame_counts", {32'(bus.vtx_count), 32'(bus.tri_count)}, {32'(f.vc), 32'(f.tc)});
        end
      end
    end
  end

  initial begin
    int t0;
    logic [1:0] ty;
    int len;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    bus.vtx_rdy    = 1'b1;
    bus.tri_rdy    = 1'b1;
    bus.scene_clr  = 1'b0;
    rnd_rdy = 1'b0; rnd_stall = 1'b0;
    m_clear();
    repeat (3) @(negedge clk);
    check("rst_flags", 64'({bus.busy, bus.fifo_rd_en, bus.vtx_we, bus.tri_we, bus.cfg_we,
                            bus.frame_done, bus.err_overflow, bus.err_format}), 64'd0);
    check("rst_counts", {32'(bus.vtx_count), 32'(bus.tri_count)}, 64'd0);
    check("rst_data_addr", {bus.mem_wdata, 32'({bus.vtx_addr, bus.tri_addr, bus.cfg_addr})}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain vertex packet, header-to-first-write latency.
    send_pkt(2'b01, 3);
    wait_sig("hdr_rd", 0);
    t0 = cyc;
    @(negedge clk);
    check("busy_after_hdr", 64'(bus.busy), 64'd1);
    wait_sig("first_vtx_we", 1);
    check("hdr_to_write_latency", 64'(cyc - t0), 64'd5);
    settle("vtx3");

    // Backpressure on the second word of a vertex packet.
    send_pkt(2'b01, 3);
    wait_sig("bp_w1", 1);
    @(posedge clk); #1 bus.vtx_rdy = 1'b0;
    wait_sig("bp_w2", 1);
    check("bp_stalled_addr", 64'(bus.vtx_addr), 64'd4);
    repeat (3) @(posedge clk);
    #1 bus.vtx_rdy = 1'b1;
    settle("backpressure");

    // End of frame.
    send_pkt(2'b11, 0);
    send_pkt(2'b01, 5);
    send_pkt(2'b10, 2);
    send_pkt(2'b11, 0);
    send_pkt(2'b01, 2);
    settle("eof");
    check("eof_counts", {32'(bus.vtx_count), 32'(bus.tri_count)}, {32'd5, 32'd2});

    // Oversized config packet is flushed, next packet still decoded.
    send_pkt(2'b00, 20);
    send_pkt(2'b01, 2);
    send_pkt(2'b00, 16);
    settle("format");
    check("format_flag", 64'(bus.err_format), 64'd1);

    // Vertex memory overflow.
    send_pkt(2'b11, 0);
    send_pkt(2'b01, VDEPTH + 2);
    settle("overflow");
    check("overflow_flag", 64'(bus.err_overflow), 64'd1);

    // scene_clr mid-packet: packet completes, clear applies in IDLE.
    send_pkt(2'b10, 4);
    m_clear();
    wait_sig("clr_tri_we", 2);
    @(posedge clk); #1 bus.scene_clr = 1'b1;
    @(posedge clk); #1 bus.scene_clr = 1'b0;
    wait_sig("clr_idle", 3);
    check("errs_before_clear", 64'({bus.err_overflow, bus.err_format}), 64'd3);
    @(negedge clk);
    check("errs_after_clear", 64'({bus.err_overflow, bus.err_format}), 64'd0);
    send_pkt(2'b01, 1);
    send_pkt(2'b10, 1);
    send_pkt(2'b11, 0);
    settle("after_clear");

    // Randomized traffic with random ready and FIFO gaps.
    rnd_rdy = 1'b1;
    rnd_stall = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ty = 2'($urandom_range(0, 3));
      case (ty)
        2'b11:   len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
        2'b00:   len = ($urandom_range(0, 5) == 0) ? $urandom_range(17, 20) : $urandom_range(0, 16);
        default: len = $urandom_range(0, 6);
      endcase
      send_pkt(ty, len);
    end
    send_pkt(2'b11, 0);
    settle("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scene_packet_dispatcher.md
Name: scene_packet_dispatcher

Overview:
- Drains the receive FIFO filled by the SPI front end, parses each packet header, and steers payload words to the vertex memory, triangle memory, or config register file.
- Maintains append pointers into both scene memories and signals end-of-frame to the ray-tracing core.
- Sits between the SPI receive FIFO read port and the scene-memory write ports.

Parameters:
- DATA_W, 32, FIFO word and memory write-data width
- VTX_ADDR_W, 10, vertex memory address width (depth 2^VTX_ADDR_W)
- TRI_ADDR_W, 10, triangle memory address width
- CFG_DEPTH, 16, number of config registers (cfg_addr width = clog2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  receive FIFO empty
- fifo_rd_en  out  1  FIFO read strobe; data appears on fifo_dout the next cycle (non-FWFT)
- fifo_dout  in  DATA_W  FIFO read data
- vtx_we  out  1  vertex write valid
- vtx_rdy  in  1  vertex memory accepts write
- vtx_addr  out  VTX_ADDR_W  vertex write address
- tri_we  out  1  triangle write valid
- tri_rdy  in  1  triangle memory accepts write
- tri_addr  out  TRI_ADDR_W  triangle write address
- mem_wdata  out  DATA_W  write data shared by vtx, tri and cfg ports
- cfg_we  out  1  config register write (always accepted)
- cfg_addr  out  clog2(CFG_DEPTH)  config register index
- scene_clr  in  1  request to zero pointers and errors
- frame_done  out  1  one-cycle pulse on END_OF_FRAME
- vtx_count  out  VTX_ADDR_W+1  vertex words in last completed frame
- tri_count  out  TRI_ADDR_W+1  triangle words in last completed frame
- err_overflow  out  1  sticky: payload dropped because a memory was full
- err_format  out  1  sticky: malformed header
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; all outputs, pointers, counts, errors, pending-clear flag = 0.
- Header word: [31:30] type (00 CONFIG, 01 VERTEX, 10 TRIANGLE, 11 END_OF_FRAME); [7:0] payload length L; other bits ignored.
- States: IDLE, HDR_CAP, DECODE, PAY_REQ, PAY_CAP, PAY_WR, FLUSH.
- IDLE: if pending clear, apply it (pointers, errors = 0), stay one cycle. Else if !fifo_empty, pulse fifo_rd_en -> HDR_CAP.
- HDR_CAP: latch type and L into registers -> DECODE.
- DECODE: remaining = L.
  - EOF with L == 0: copy vtx_ptr/tri_ptr into vtx_count/tri_count, pulse frame_done, zero both pointers -> IDLE.
  - EOF with L != 0: set err_format -> FLUSH.
  - CONFIG with L > CFG_DEPTH: set err_format -> FLUSH.
  - L == 0 (any other type): -> IDLE.
  - Otherwise -> PAY_REQ; cfg index = 0.
- PAY_REQ: wait while fifo_empty. Else pulse fifo_rd_en -> PAY_CAP.
- PAY_CAP: register fifo_dout into mem_wdata -> PAY_WR.
- PAY_WR:
  - VERTEX: vtx_we = 1 with vtx_addr = vtx_ptr; hold we, addr and data stable until vtx_rdy. On the accept cycle, vtx_ptr++.
  - If vtx_ptr == 2^VTX_ADDR_W (full): no write; set err_overflow; word is dropped.
  - TRIANGLE: same rules using tri_* signals.
  - CONFIG: cfg_we = 1 for one cycle at cfg index, then index++.
  - After each word, remaining--. If remaining == 0 -> IDLE, else -> PAY_REQ.
- FLUSH: read and discard L payload words (same req/cap pacing, no writes) -> IDLE. Keeps the FIFO aligned to packet boundaries.
- Throughput: at most one payload word per 3 cycles; header-to-first-write latency is 5 cycles when the FIFO is non-empty and rdy is high.
- Pointers are VTX_ADDR_W+1 / TRI_ADDR_W+1 bits wide and saturate at full; they never wrap.
- scene_clr is sampled every cycle into the pending flag and applied only in IDLE, so a packet is never aborted mid-payload. If scene_clr arrives in the same cycle as an EOF in DECODE, the EOF completes first; the clear applies in the next IDLE cycle.
- At most one of vtx_we, tri_we, cfg_we is high in any cycle.
- Async reset mid-packet returns to IDLE immediately. Any residual FIFO contents are the upstream's responsibility, since the SPI side clears on its own cs_n cycle.

Test Plan:
- Vertex packet: hdr 0x4000_0003, payload A, B, C, vtx_rdy = 1 -> three vtx_we accepts at addr 0, 1, 2 with data A, B, C; vtx_ptr = 3; busy drops afterwards.
- Backpressure: vtx_rdy low for 4 cycles during word 2 -> vtx_we, vtx_addr = 1 and mem_wdata held stable; exactly one write when rdy rises; no extra fifo_rd_en while stalled.
- EOF: 5 vertex words + 2 triangle words, then hdr 0xC000_0000 -> frame_done pulses once; vtx_count = 5, tri_count = 2; next vertex packet writes at addr 0.
- Format errors: hdr 0x0000_0014 (CONFIG, L = 20) followed by 20 words -> err_format = 1, no cfg_we, all 20 words read. The following vertex packet is decoded correctly.
- Overflow: VTX_ADDR_W = 2, send 6 vertex words -> writes at addr 0..3 only; err_overflow = 1; 6 FIFO reads.
- scene_clr asserted mid-triangle packet -> packet completes normally; pointers and errors are 0 one cycle after returning to IDLE.
